// File: rtl/bcd_counter_param_if.sv
// Control/status bundle for bcd_counter_param: count controls in, BCD value and pulses out.
interface bcd_counter_param_if #(
    parameter int DIGITS = 3
) ();
    logic                  en;
    logic                  up;
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   bcd;
    logic                  wrap;
    logic                  is_zero;
    logic                  load_err;

    modport master (
        output en, up, clear, load, load_val,
        input  bcd, wrap, is_zero, load_err
    );

    modport slave (
        input  en, up, clear, load, load_val,
        output bcd, wrap, is_zero, load_err
    );
endinterface

// File: rtl/bcd_counter_param.sv
// N-digit synchronous BCD counter with modulus, up/down, load, clear and wrap/load-error pulses.
// Arithmetic stays in BCD throughout; the modulus limit is a constant BCD vector.
module bcd_counter_param #(
    parameter int DIGITS  = 3,
    parameter int MODULUS = 1000
) (
    input  logic               clk,
    input  logic               rst,
    bcd_counter_param_if.slave bus
);
    localparam int W = 4 * DIGITS;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam int           SPAN = pow10(DIGITS);
    localparam logic [W-1:0] TOP  = to_bcd(MODULUS - 1);

    if (DIGITS < 1 || DIGITS > 6) begin : g_bad_digits
        $error("bcd_counter_param: DIGITS must be 1..6");
    end
    if (MODULUS < 2 || MODULUS > SPAN) begin : g_bad_modulus
        $error("bcd_counter_param: MODULUS must be 2..10**DIGITS");
    end

    // Ripple carry: a digit steps only while every lower digit sits at 9.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic digits_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    logic         wrap_pulse;
    logic         wrap_nxt;
    logic         err_pulse;
    logic         err_nxt;
    logic         load_ok;

    // With every digit legal, BCD vectors order the same as their decimal values.
    assign load_ok = digits_valid(bus.load_val) && (bus.load_val <= TOP);

    always_comb begin
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (bus.clear) begin
            cnt_nxt = '0;
        end else if (bus.load) begin
            if (load_ok) cnt_nxt = bus.load_val;
            else         err_nxt = 1'b1;
        end else if (bus.en) begin
            if (bus.up) begin
                if (cnt == TOP) begin
                    cnt_nxt  = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    cnt_nxt = bcd_inc(cnt);
                end
            end else begin
                if (cnt == '0) begin
                    cnt_nxt  = TOP;
                    wrap_nxt = 1'b1;
                end else begin
                    cnt_nxt = bcd_dec(cnt);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            wrap_pulse <= wrap_nxt;
            err_pulse  <= err_nxt;
        end
    end

    assign bus.bcd      = cnt;
    assign bus.wrap     = wrap_pulse;
    assign bus.load_err = err_pulse;
    assign bus.is_zero  = (cnt == '0);
endmodule

// File: tb/tb_bcd_counter_param.sv
// Bench for bcd_counter_param: vector table, directed corner sequences and randomized run
// against an integer-valued reference model, over three parameter sets.
module tb_bcd_counter_param;
    logic clk = 1'b0;
    logic rst3 = 1'b0;
    logic rst2 = 1'b0;
    logic rst1 = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    bcd_counter_param_if #(.DIGITS(3)) if3 ();
    bcd_counter_param_if #(.DIGITS(2)) if2 ();
    bcd_counter_param_if #(.DIGITS(1)) if1 ();

    bcd_counter_param #(.DIGITS(3), .MODULUS(1000)) u3 (.clk(clk), .rst(rst3), .bus(if3));
    bcd_counter_param #(.DIGITS(2), .MODULUS(60))   u2 (.clk(clk), .rst(rst2), .bus(if2));
    bcd_counter_param #(.DIGITS(1), .MODULUS(2))    u1 (.clk(clk), .rst(rst1), .bus(if1));

    typedef struct {
        bit          clr, ld, en, up;
        logic [11:0] lv;
        logic [11:0] eb;
        bit          ew, ee;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit clr, bit ld, bit en, bit up, logic [11:0] lv,
                                logic [11:0] eb, bit ew, bit ee);
        vec_t v;
        v.clr = clr; v.ld = ld; v.en = en; v.up = up;
        v.lv = lv; v.eb = eb; v.ew = ew; v.ee = ee;
        return v;
    endfunction

    function automatic logic [31:0] to_bcd(int v);
        logic [31:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r = r | (32'(t % 10) << (4 * i));
            t = t / 10;
        end
        return r;
    endfunction

    // Reference behaviour on a plain integer count.
    task automatic model_step(input int md, input int nd, input bit clr, input bit ld,
                              input bit en, input bit up, input logic [31:0] lv,
                              inout int cnt, output bit w, output bit e);
        bit bad;
        int val;
        int d;
        w = 1'b0;
        e = 1'b0;
        bad = 1'b0;
        val = 0;
        if (clr) begin
            cnt = 0;
        end else if (ld) begin
            for (int i = nd - 1; i >= 0; i--) begin
                d = int'((lv >> (4 * i)) & 32'hF);
                if (d > 9) bad = 1'b1;
                val = val * 10 + d;
            end
            if (bad || val >= md) e = 1'b1;
            else cnt = val;
        end else if (en) begin
            if (up) begin
                if (cnt == md - 1) begin cnt = 0; w = 1'b1; end
                else cnt = cnt + 1;
            end else begin
                if (cnt == 0) begin cnt = md - 1; w = 1'b1; end
                else cnt = cnt - 1;
            end
        end
    endtask

    function automatic logic [31:0] pick(int md, int nd);
        logic [31:0] mask;
        int span;
        mask = (32'd1 << (4 * nd)) - 32'd1;
        span = 1;
        for (int i = 0; i < nd; i++) span = span * 10;
        case ($urandom_range(0, 3))
            0: return to_bcd(int'($urandom_range(0, md - 1)));
            1: return $urandom & mask;
            2: return to_bcd(int'($urandom_range(0, span - 1)));
            default: return to_bcd(md - 1);
        endcase
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(string nm, logic [11:0] b, bit w, bit e);
        check({nm, " bcd"}, {20'd0, if3.bcd}, {20'd0, b});
        check({nm, " wrap"}, {31'd0, if3.wrap}, {31'd0, w});
        check({nm, " load_err"}, {31'd0, if3.load_err}, {31'd0, e});
        check({nm, " is_zero"}, {31'd0, if3.is_zero}, {31'd0, (b == 12'd0)});
    endtask

    task automatic chk2(string nm, logic [7:0] b, bit w, bit e);
        check({nm, " bcd"}, {24'd0, if2.bcd}, {24'd0, b});
        check({nm, " wrap"}, {31'd0, if2.wrap}, {31'd0, w});
        check({nm, " load_err"}, {31'd0, if2.load_err}, {31'd0, e});
        check({nm, " is_zero"}, {31'd0, if2.is_zero}, {31'd0, (b == 8'd0)});
    endtask

    task automatic chk1(string nm, logic [3:0] b, bit w);
        check({nm, " bcd"}, {28'd0, if1.bcd}, {28'd0, b});
        check({nm, " wrap"}, {31'd0, if1.wrap}, {31'd0, w});
    endtask

    task automatic drive3(bit clr, bit ld, bit en, bit up, logic [11:0] lv);
        if3.clear = clr; if3.load = ld; if3.en = en; if3.up = up; if3.load_val = lv;
    endtask

    initial begin
        int m3, m2, wraps;
        bit w3, e3, w2, e2;
        bit r3, c3, l3, n3, d3, r2, c2, l2, n2, d2;
        logic [31:0] lv3, lv2;

        drive3(0, 0, 0, 1, 12'h000);
        if2.clear = 0; if2.load = 0; if2.en = 0; if2.up = 0; if2.load_val = 8'h00;
        if1.clear = 0; if1.load = 0; if1.en = 0; if1.up = 0; if1.load_val = 4'h0;

        // Reset held two edges with count enabled.
        drive3(0, 0, 1, 1, 12'h000);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk3("reset3", 12'h000, 0, 0);
        end
        rst3 = 1'b1;

        // Two full up-count wraps.
        for (int pass = 0; pass < 2; pass++) begin
            wraps = 0;
            for (int i = 0; i < (pass == 0 ? 999 : 998); i++) begin
                tick();
                if (if3.wrap) wraps++;
            end
            check("early wrap count", 32'(wraps), 32'd0);
            chk3("count to 999", 12'h999, 0, 0);
            tick();
            chk3("wrap 999->000", 12'h000, 1, 0);
            tick();
            chk3("after wrap", 12'h001, 0, 0);
        end

        // Vector table on the 3-digit counter.
        drive3(0, 0, 0, 1, 12'h000);
        tick();
        drive3(1, 0, 0, 1, 12'h000);
        tick();
        tbl.push_back(mk(0, 1, 0, 1, 12'h998, 12'h998, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 12'h000, 12'h999, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 12'h000, 12'h000, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 12'h9A0, 12'h000, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 12'h000, 12'h000, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 12'h999, 12'h999, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 12'h555, 12'h000, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 12'h999, 12'h999, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 12'h123, 12'h123, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 12'h100, 12'h100, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 12'h000, 12'h099, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 12'h000, 12'h100, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 12'h000, 12'h099, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 12'h000, 12'h098, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 12'h0A5, 12'h098, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 12'h000, 12'h000, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 12'h000, 12'h999, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 12'h000, 12'h998, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            drive3(tbl[i].clr, tbl[i].ld, tbl[i].en, tbl[i].up, tbl[i].lv);
            tick();
            chk3($sformatf("vec%0d", i), tbl[i].eb, tbl[i].ew, tbl[i].ee);
        end

        // Reset overriding a load+count edge.
        drive3(0, 1, 0, 1, 12'h457);
        tick();
        chk3("load 457", 12'h457, 0, 0);
        drive3(0, 1, 1, 1, 12'h9A0);
        rst3 = 1'b0;
        tick();
        chk3("reset mid-op", 12'h000, 0, 0);
        rst3 = 1'b1;
        drive3(0, 0, 1, 1, 12'h000);
        tick();
        chk3("resume after reset", 12'h001, 0, 0);

        // Mod-60 down counter.
        if2.en = 1'b1; if2.up = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk2("reset2", 8'h00, 0, 0);
        end
        rst2 = 1'b1;
        tick();
        chk2("down 0->59", 8'h59, 1, 0);
        tick();
        chk2("down 58", 8'h58, 0, 0);
        tick();
        chk2("down 57", 8'h57, 0, 0);
        if2.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk2("hold 57", 8'h57, 0, 0);
        end
        if2.load = 1'b1; if2.load_val = 8'h60;
        tick();
        chk2("load 60 rejected", 8'h57, 0, 1);
        if2.load = 1'b0;
        tick();
        chk2("load_err one cycle", 8'h57, 0, 0);

        // Mod-2: consecutive wraps by alternating direction.
        if1.en = 1'b1; if1.up = 1'b0;
        tick();
        chk1("reset1", 4'h0, 0);
        rst1 = 1'b1;
        tick();
        chk1("mod2 down wrap", 4'h1, 1);
        if1.up = 1'b1;
        tick();
        chk1("mod2 up wrap", 4'h0, 1);
        if1.up = 1'b0;
        tick();
        chk1("mod2 down wrap again", 4'h1, 1);
        if1.en = 1'b0;
        tick();
        chk1("mod2 hold", 4'h1, 0);

        // Randomized run against the integer model.
        m3 = 998;
        m2 = 57;
        drive3(0, 1, 0, 1, 12'h998);
        tick();
        chk3("rnd seed3", 12'h998, 0, 0);
        for (int c = 0; c < 800; c++) begin
            r3 = ($urandom_range(0, 49) == 0);
            c3 = ($urandom_range(0, 15) == 0);
            l3 = ($urandom_range(0, 7) == 0);
            n3 = ($urandom_range(0, 3) != 0);
            d3 = ($urandom_range(0, 2) != 0);
            lv3 = pick(1000, 3);
            r2 = ($urandom_range(0, 49) == 0);
            c2 = ($urandom_range(0, 15) == 0);
            l2 = ($urandom_range(0, 5) == 0);
            n2 = ($urandom_range(0, 3) != 0);
            d2 = ($urandom_range(0, 1) != 0);
            lv2 = pick(60, 2);
            rst3 = ~r3;
            drive3(c3, l3, n3, d3, lv3[11:0]);
            rst2 = ~r2;
            if2.clear = c2; if2.load = l2; if2.en = n2; if2.up = d2; if2.load_val = lv2[7:0];
            tick();
            if (r3) begin m3 = 0; w3 = 0; e3 = 0; end
            else model_step(1000, 3, c3, l3, n3, d3, {20'd0, lv3[11:0]}, m3, w3, e3);
            if (r2) begin m2 = 0; w2 = 0; e2 = 0; end
            else model_step(60, 2, c2, l2, n2, d2, {24'd0, lv2[7:0]}, m2, w2, e2);
            chk3("rnd3", to_bcd(m3) & 32'hFFF, w3, e3);
            chk2("rnd2", to_bcd(m2) & 32'hFF, w2, e2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bcd_counter_param.md
Name: bcd_counter_param

Overview:
- Parametrised N-digit synchronous BCD counter.
- Successor to the fixed 3-digit millisecond counter (000-999); generalised in digit count and modulus, with added up/down mode, enable, parallel load, clear and wrap/borrow pulses.
- Serves as the common building block for the digital clock chain (ms, sec, min, hour stages cascaded through the wrap pulse).

Parameters:
- DIGITS, 3: number of BCD digits; legal 1..6.
- MODULUS, 1000: count range is 0..MODULUS-1; legal 2..10^DIGITS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising clk edge.
- en  in  1  count enable; one step per clk edge while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clear  in  1  synchronous clear to zero.
- load  in  1  parallel load strobe.
- load_val  in  4*DIGITS  BCD load value; digit 0 (units) in bits [3:0].
- bcd  out  4*DIGITS  current count in BCD; digit 0 in bits [3:0].
- wrap  out  1  one-cycle pulse: count wrapped (up: MODULUS-1 -> 0; down: 0 -> MODULUS-1).
- is_zero  out  1  high while bcd == 0.
- load_err  out  1  one-cycle pulse: rejected load.

Behaviour:
- Reset:
  - rst low at a rising edge sets bcd=0, wrap=0, load_err=0; is_zero=1.
  - Overrides all other inputs, including mid-count and mid-wrap.
- Per-edge priority, highest first: rst, clear, load, en. Exactly one action per edge.
- clear:
  - bcd -> 0, wrap=0.
  - Ignores en/load that cycle; no wrap pulse even if the count was MODULUS-1.
- load:
  - Accepted only if every digit of load_val is ≤ 9 and its value is < MODULUS; then bcd <- load_val.
  - Otherwise bcd is unchanged and load_err=1 for the following cycle.
  - No count step on a load edge; wrap=0.
- en=1, up=1:
  - Digit i increments when all lower digits are 9, rolling 9 -> 0 with carry.
  - At value MODULUS-1 the next value is 0 and wrap=1 for one cycle.
- en=1, up=0:
  - Digit i decrements when all lower digits are 0, rolling 0 -> 9 with borrow.
  - At value 0 the next value is MODULUS-1 (BCD) and wrap=1 for one cycle.
- en=0: bcd holds; wrap=0.
- Timing:
  - wrap and load_err are registered; high during exactly the cycle after the causing edge, coincident with the new bcd value.
  - Back-to-back wraps (e.g. MODULUS=2 with en held) produce wrap high on consecutive cycles.
- is_zero is combinational from bcd.
- Latency: bcd updates on the edge where the action is sampled; no pipeline.
- Wrap detection compares the full BCD vector against constant BCD(MODULUS-1) and 0. No binary conversion in the datapath.
- Direction change takes effect on the next enabled edge; no glitch or extra step.
- Illegal parameters (MODULUS > 10^DIGITS or < 2) are an elaboration-time error.

Test Plan:
- rst low for 2 edges, then high with en=1, up=1, DIGITS=3, MODULUS=1000:
  - bcd=000 and is_zero=1 during reset.
  - After 999 edges bcd=999.
  - Next edge bcd=000 with wrap=1 for exactly one cycle.
  - Repeat for a second full wrap.
- DIGITS=2, MODULUS=60, up=0 from reset:
  - First enabled edge: bcd=59, wrap=1.
  - Subsequent edges: 58, 57.
  - Hold en=0 for 5 edges: bcd stays 57, wrap=0.
- DIGITS=3: load load_val=0x998, then 2 up edges:
  - bcd=998, 999, then 000 with wrap=1.
  - load 0x9A0 (bad digit): bcd unchanged, load_err=1 one cycle.
  - MODULUS=60 with load 0x60 (≥ MODULUS): rejected, load_err=1.
- Simultaneous inputs at bcd=999:
  - clear=1, load=1, en=1: bcd=000, wrap=0.
  - load=1 with en=1, load_val=0x123: bcd=123, no increment.
- Reset mid-operation:
  - Count to 0x457, assert rst with clear=0, load=1, en=1: next bcd=000, no wrap or load_err pulse.
  - Release rst: counting resumes at 001.
- Direction switch at carry boundary:
  - At bcd=100 toggle up=0: next 099.
  - Toggle up=1: 100.
  - No wrap pulse throughout.
